// File: rtl/cmd_proto_pkg.sv
// Shared definitions for the UART command protocol: frame opcodes, request
// op codes, per-op frame/response lengths, master FSM encodings and a helper
// that yields the frame byte for a given op and byte index.
package cmd_proto_pkg;

    // Command opcodes, first byte of every frame (shared with the system controller)
    localparam logic [7:0] OPC_WRITE   = 8'hAA;
    localparam logic [7:0] OPC_READ    = 8'hBB;
    localparam logic [7:0] OPC_ALU     = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

    // Request op codes as presented on REQ_OP
    typedef enum logic [1:0] {
        OP_WRITE   = 2'd0,
        OP_READ    = 2'd1,
        OP_ALU     = 2'd2,
        OP_ALU_NOP = 2'd3
    } req_op_e;

    // Frame lengths in bytes, opcode included
    localparam logic [2:0] FRAME_LEN_WRITE   = 3'd3;
    localparam logic [2:0] FRAME_LEN_READ    = 3'd2;
    localparam logic [2:0] FRAME_LEN_ALU     = 3'd4;
    localparam logic [2:0] FRAME_LEN_ALU_NOP = 3'd2;

    // Response lengths in bytes
    localparam logic [1:0] RSP_LEN_WRITE   = 2'd0;
    localparam logic [1:0] RSP_LEN_READ    = 2'd1;
    localparam logic [1:0] RSP_LEN_ALU     = 2'd2;
    localparam logic [1:0] RSP_LEN_ALU_NOP = 2'd2;

    // Master FSM states, plain binary
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_SEND     = 2'b01,
        ST_WAIT_RSP = 2'b10,
        ST_DONE     = 2'b11
    } fsm_state_e;

    function automatic logic [2:0] frame_len(input req_op_e op);
        logic [2:0] len;
        len = FRAME_LEN_WRITE;
        case (op)
            OP_WRITE:   len = FRAME_LEN_WRITE;
            OP_READ:    len = FRAME_LEN_READ;
            OP_ALU:     len = FRAME_LEN_ALU;
            OP_ALU_NOP: len = FRAME_LEN_ALU_NOP;
            default:    len = FRAME_LEN_WRITE;
        endcase
        return len;
    endfunction

    function automatic logic [1:0] rsp_len(input req_op_e op);
        logic [1:0] len;
        len = RSP_LEN_WRITE;
        case (op)
            OP_WRITE:   len = RSP_LEN_WRITE;
            OP_READ:    len = RSP_LEN_READ;
            OP_ALU:     len = RSP_LEN_ALU;
            OP_ALU_NOP: len = RSP_LEN_ALU_NOP;
            default:    len = RSP_LEN_WRITE;
        endcase
        return len;
    endfunction

    // Byte at position idx of the frame for op; out-of-range indices give 0
    function automatic logic [7:0] frame_byte(
        input req_op_e    op,
        input logic [1:0] idx,
        input logic [3:0] addr,
        input logic [7:0] data,
        input logic [7:0] opb,
        input logic [3:0] fun
    );
        logic [7:0] b;
        b = 8'h00;
        case (op)
            OP_WRITE: begin
                case (idx)
                    2'd0:    b = OPC_WRITE;
                    2'd1:    b = {4'h0, addr};
                    2'd2:    b = data;
                    default: b = 8'h00;
                endcase
            end
            OP_READ: begin
                case (idx)
                    2'd0:    b = OPC_READ;
                    2'd1:    b = {4'h0, addr};
                    default: b = 8'h00;
                endcase
            end
            OP_ALU: begin
                case (idx)
                    2'd0:    b = OPC_ALU;
                    2'd1:    b = data;
                    2'd2:    b = opb;
                    default: b = {4'h0, fun};
                endcase
            end
            OP_ALU_NOP: begin
                case (idx)
                    2'd0:    b = OPC_ALU_NOP;
                    2'd1:    b = {4'h0, fun};
                    default: b = 8'h00;
                endcase
            end
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cmd_frame_master_if.sv
// Request / TX / RX / response bundle of the command frame master.
// master: the frame master itself. slave: the host or harness driving it.
interface cmd_frame_master_if;
    logic        REQ_VLD;
    logic        REQ_RDY;
    logic [1:0]  REQ_OP;
    logic [3:0]  REQ_ADDR;
    logic [7:0]  REQ_DATA;
    logic [7:0]  REQ_OPB;
    logic [3:0]  REQ_FUN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_RDY;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic        RSP_VLD;
    logic [15:0] RSP_DATA;
    logic        RSP_ERR;
    logic        BUSY;

    modport master (
        input  REQ_VLD, REQ_OP, REQ_ADDR, REQ_DATA, REQ_OPB, REQ_FUN,
        input  TX_RDY, RX_P_DATA, RX_D_VLD,
        output REQ_RDY, TX_P_DATA, TX_D_VLD, RSP_VLD, RSP_DATA, RSP_ERR, BUSY
    );

    modport slave (
        output REQ_VLD, REQ_OP, REQ_ADDR, REQ_DATA, REQ_OPB, REQ_FUN,
        output TX_RDY, RX_P_DATA, RX_D_VLD,
        input  REQ_RDY, TX_P_DATA, TX_D_VLD, RSP_VLD, RSP_DATA, RSP_ERR, BUSY
    );
endinterface

// File: rtl/cmd_rsp_timer.sv
// Inter-byte response timer. i_clear reloads the count to zero, i_tick
// advances it, and o_expire flags the tick on which the count sits at
// TIMEOUT_CYC-1, i.e. TIMEOUT_CYC idle cycles since the last clear.
module cmd_rsp_timer #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int TO_W        = 13
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_expire
);
    localparam logic [TO_W-1:0] L_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] r_cnt;

    // Count idle ticks; clear takes priority, wrap after expiry
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            if (r_cnt == L_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_expire = i_tick && (r_cnt == L_LAST);

endmodule

// File: rtl/cmd_frame_master.sv
// Host-side initiator of the UART command protocol: takes one request,
// sends its command frame byte by byte, gathers 0/1/2 response bytes and
// issues a single completion pulse.
// Optional macro CMD_MASTER_TIMEOUT_EN: enables the inter-byte response
// timeout (cmd_rsp_timer) and the RSP_ERR abort path; without it WAIT_RSP
// waits indefinitely and RSP_ERR stays 0.
module cmd_frame_master
    import cmd_proto_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096,
    parameter int TO_W        = 13
) (
    input  logic              CLK,
    input  logic              RST,
    cmd_frame_master_if.master bus
);

    fsm_state_e  r_state;
    req_op_e     r_op;
    logic [3:0]  r_addr;
    logic [7:0]  r_data;
    logic [7:0]  r_opb;
    logic [3:0]  r_fun;
    logic [1:0]  r_idx;
    logic [1:0]  r_rx_cnt;
    logic        r_req_rdy;
    logic        r_tx_vld;
    logic [7:0]  r_tx_data;
    logic        r_rsp_vld;
    logic [15:0] r_rsp_data;
    logic        r_rsp_err;
    logic        r_busy;

    req_op_e     w_req_op;
    logic        w_tx_fire;
    logic        w_last_byte;
    logic        w_last_rx;
    logic        w_expire;

    assign w_req_op    = req_op_e'(bus.REQ_OP);
    assign w_tx_fire   = r_tx_vld && bus.TX_RDY;
    assign w_last_byte = ({1'b0, r_idx} == (frame_len(r_op) - 3'd1));
    assign w_last_rx   = ((r_rx_cnt + 2'd1) == rsp_len(r_op));

`ifdef CMD_MASTER_TIMEOUT_EN
    logic w_tmr_clear;
    logic w_tmr_tick;

    // Reload on WAIT_RSP entry and on every received byte; count idle cycles in WAIT_RSP
    assign w_tmr_clear = ((r_state == ST_SEND) && w_tx_fire && w_last_byte) ||
                         ((r_state == ST_WAIT_RSP) && bus.RX_D_VLD);
    assign w_tmr_tick  = (r_state == ST_WAIT_RSP) && !bus.RX_D_VLD;

    cmd_rsp_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_rsp_timer (
        .CLK      (CLK),
        .RST      (RST),
        .i_clear  (w_tmr_clear),
        .i_tick   (w_tmr_tick),
        .o_expire (w_expire)
    );
`else
    logic w_unused_cfg;

    // No timeout hardware: never expire, configuration knobs are inert
    assign w_expire     = 1'b0;
    assign w_unused_cfg = ^{TO_W'(TIMEOUT_CYC)};
`endif

    // Master FSM with all handshake and response outputs registered
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_WRITE;
            r_addr     <= '0;
            r_data     <= '0;
            r_opb      <= '0;
            r_fun      <= '0;
            r_idx      <= '0;
            r_rx_cnt   <= '0;
            r_req_rdy  <= 1'b1;
            r_tx_vld   <= 1'b0;
            r_tx_data  <= '0;
            r_rsp_vld  <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rsp_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_req_rdy <= 1'b1;
                    r_busy    <= 1'b0;
                    r_tx_vld  <= 1'b0;
                    if (bus.REQ_VLD) begin
                        r_op      <= w_req_op;
                        r_addr    <= bus.REQ_ADDR;
                        r_data    <= bus.REQ_DATA;
                        r_opb     <= bus.REQ_OPB;
                        r_fun     <= bus.REQ_FUN;
                        r_idx     <= 2'd0;
                        r_tx_data <= frame_byte(w_req_op, 2'd0, bus.REQ_ADDR,
                                                bus.REQ_DATA, bus.REQ_OPB, bus.REQ_FUN);
                        r_tx_vld  <= 1'b1;
                        r_req_rdy <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (w_tx_fire) begin
                        if (w_last_byte) begin
                            r_tx_vld   <= 1'b0;
                            r_tx_data  <= 8'h00;
                            r_idx      <= 2'd0;
                            r_rsp_data <= '0;
                            if (rsp_len(r_op) == 2'd0) begin
                                // Writes have no response: complete straight away
                                r_rsp_vld <= 1'b1;
                                r_rsp_err <= 1'b0;
                                r_state   <= ST_DONE;
                            end else begin
                                r_rx_cnt <= 2'd0;
                                r_state  <= ST_WAIT_RSP;
                            end
                        end else begin
                            r_idx     <= r_idx + 2'd1;
                            r_tx_data <= frame_byte(r_op, r_idx + 2'd1, r_addr,
                                                    r_data, r_opb, r_fun);
                        end
                    end
                end

                ST_WAIT_RSP: begin
                    // A received byte takes precedence over a coincident timeout
                    if (bus.RX_D_VLD) begin
                        if (r_rx_cnt == 2'd0) begin
                            r_rsp_data[7:0] <= bus.RX_P_DATA;
                        end else begin
                            r_rsp_data[15:8] <= bus.RX_P_DATA;
                        end
                        r_rx_cnt <= r_rx_cnt + 2'd1;
                        if (w_last_rx) begin
                            r_rsp_vld <= 1'b1;
                            r_rsp_err <= 1'b0;
                            r_state   <= ST_DONE;
                        end
                    end else if (w_expire) begin
                        r_rsp_vld <= 1'b1;
                        r_rsp_err <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_req_rdy <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_req_rdy <= 1'b1;
                    r_busy    <= 1'b0;
                    r_tx_vld  <= 1'b0;
                    r_tx_data <= 8'h00;
                    r_idx     <= 2'd0;
                end
            endcase
        end
    end

    assign bus.REQ_RDY   = r_req_rdy;
    assign bus.TX_P_DATA = r_tx_data;
    assign bus.TX_D_VLD  = r_tx_vld;
    assign bus.RSP_VLD   = r_rsp_vld;
    assign bus.RSP_DATA  = r_rsp_data;
    assign bus.RSP_ERR   = r_rsp_err;
    assign bus.BUSY      = r_busy;

endmodule

// File: tb/tb_cmd_frame_master.sv
// Self-checking bench for cmd_frame_master: directed scenarios plus a
// randomized back-to-back run, checked against a frame/response model.
module tb_cmd_frame_master;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    cmd_frame_master_if u_if ();

    cmd_frame_master #(
        .TIMEOUT_CYC (16),
        .TO_W        (5)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (u_if)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int g_cycle = 0;
    int g_vld_cnt = 0;

    logic [7:0]  g_tx_seen[$];
    logic [7:0]  g_exp_frame[$];
    logic [7:0]  g_rx_bytes[$];
    logic [15:0] g_rsp_data;
    logic        g_rsp_err;
    logic        g_rsp_seen;
    logic        g_vld_after;
    logic        g_rdy_after;
    int          g_latency;
    int          g_tx_cycles;
    int          g_unstable;

    always @(posedge CLK) g_cycle <= g_cycle + 1;
    always @(negedge CLK) if (u_if.RSP_VLD === 1'b1) g_vld_cnt <= g_vld_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_frame(input logic [1:0] op, input logic [3:0] addr,
                                        input logic [7:0] data, input logic [7:0] opb,
                                        input logic [3:0] fun);
        g_exp_frame.delete();
        case (op)
            2'd0: begin g_exp_frame.push_back(8'hAA); g_exp_frame.push_back({4'h0, addr});
                        g_exp_frame.push_back(data); end
            2'd1: begin g_exp_frame.push_back(8'hBB); g_exp_frame.push_back({4'h0, addr}); end
            2'd2: begin g_exp_frame.push_back(8'hCC); g_exp_frame.push_back(data);
                        g_exp_frame.push_back(opb); g_exp_frame.push_back({4'h0, fun}); end
            default: begin g_exp_frame.push_back(8'hDD); g_exp_frame.push_back({4'h0, fun}); end
        endcase
    endfunction

    function automatic int model_rsp_len(input logic [1:0] op);
        return (op == 2'd0) ? 0 : (op == 2'd1) ? 1 : 2;
    endfunction

    // Response word: bytes in arrival order, low byte first, unused bytes zero
    function automatic logic [15:0] model_rsp(input logic [1:0] op);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < model_rsp_len(op) && i < g_rx_bytes.size(); i++)
            r[8*i +: 8] = g_rx_bytes[i];
        return r;
    endfunction

    function automatic logic [39:0] pk_seen();
        logic [39:0] v;
        v = '0;
        v[39:32] = 8'(g_tx_seen.size());
        for (int i = 0; i < g_tx_seen.size() && i < 4; i++) v[31-8*i -: 8] = g_tx_seen[i];
        return v;
    endfunction

    function automatic logic [39:0] pk_exp();
        logic [39:0] v;
        v = '0;
        v[39:32] = 8'(g_exp_frame.size());
        for (int i = 0; i < g_exp_frame.size() && i < 4; i++) v[31-8*i -: 8] = g_exp_frame[i];
        return v;
    endfunction

    // ---------------- driver ----------------
    // Issues one request, records TX bytes (with optional stalls), feeds
    // g_rx_bytes as RX strobes and captures the completion.
    task automatic do_request(input logic [1:0] op, input logic [3:0] addr,
                              input logic [7:0] data, input logic [7:0] opb,
                              input logic [3:0] fun, input int stall, input int rx_gap,
                              input bit stray, input int max_wait);
        int n, held, t0, ri, gap;
        bit have_last;
        logic [7:0] last;
        g_tx_seen.delete();
        g_rsp_seen = 1'b0; g_rsp_data = 16'h0; g_rsp_err = 1'b0;
        g_vld_after = 1'b0; g_rdy_after = 1'b0;
        g_latency = -1; g_tx_cycles = 0; g_unstable = 0;
        model_frame(op, addr, data, opb, fun);
        n = 0;
        while (u_if.REQ_RDY !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
        if (u_if.REQ_RDY !== 1'b1) begin
            checks++; errors++;
            $display("FAIL req_accept REQ_RDY=%b required 1", u_if.REQ_RDY);
            return;
        end
        u_if.REQ_OP = op; u_if.REQ_ADDR = addr; u_if.REQ_DATA = data;
        u_if.REQ_OPB = opb; u_if.REQ_FUN = fun; u_if.REQ_VLD = 1'b1;
        u_if.TX_RDY = (stall == 0);
        @(posedge CLK); @(negedge CLK);
        u_if.REQ_VLD = 1'b0;
        held = 0; have_last = 0; last = 8'h00; n = 0;
        while (g_tx_seen.size() < g_exp_frame.size() && n < 200) begin
            if (have_last && (u_if.TX_D_VLD !== 1'b1 || u_if.TX_P_DATA !== last)) g_unstable++;
            if (u_if.TX_D_VLD === 1'b1) begin
                if (held >= stall) begin
                    u_if.TX_RDY = 1'b1; g_tx_seen.push_back(u_if.TX_P_DATA);
                    held = 0; have_last = 0;
                end else begin
                    u_if.TX_RDY = 1'b0; held++; last = u_if.TX_P_DATA; have_last = 1;
                end
            end else begin
                u_if.TX_RDY = 1'b0;
                have_last = 0;
            end
            u_if.RX_D_VLD = stray;
            u_if.RX_P_DATA = 8'($urandom);
            @(posedge CLK); @(negedge CLK); n++;
        end
        g_tx_cycles = n;
        u_if.TX_RDY = 1'b0; u_if.RX_D_VLD = 1'b0;
        t0 = g_cycle; ri = 0; gap = 0; n = 0;
        while (n <= max_wait) begin
            if (u_if.RSP_VLD === 1'b1) begin
                g_rsp_seen = 1'b1; g_rsp_data = u_if.RSP_DATA; g_rsp_err = u_if.RSP_ERR;
                g_latency = g_cycle - t0;
                break;
            end
            u_if.RX_D_VLD = 1'b0;
            if (ri < g_rx_bytes.size()) begin
                if (gap >= rx_gap) begin
                    u_if.RX_D_VLD = 1'b1; u_if.RX_P_DATA = g_rx_bytes[ri]; ri++; gap = 0;
                end else gap++;
            end
            @(posedge CLK); @(negedge CLK); n++;
        end
        u_if.RX_D_VLD = 1'b0;
        if (g_rsp_seen) begin
            @(posedge CLK); @(negedge CLK);
            g_vld_after = u_if.RSP_VLD; g_rdy_after = u_if.REQ_RDY;
        end
        $display("txn op=%0d tx_bytes=%0d tx_cyc=%0d rsp_seen=%0d data=%h err=%b lat=%0d",
                 op, g_tx_seen.size(), g_tx_cycles, g_rsp_seen, g_rsp_data, g_rsp_err, g_latency);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        u_if.REQ_VLD = 0; u_if.REQ_OP = 0; u_if.REQ_ADDR = 0; u_if.REQ_DATA = 0;
        u_if.REQ_OPB = 0; u_if.REQ_FUN = 0; u_if.TX_RDY = 0; u_if.RX_P_DATA = 0; u_if.RX_D_VLD = 0;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (u_if.REQ_RDY !== 1'b1) begin errors++; $display("FAIL reset_req_rdy got %b required 1", u_if.REQ_RDY); end
        checks++; if (u_if.TX_D_VLD !== 1'b0) begin errors++; $display("FAIL reset_tx_vld got %b required 0", u_if.TX_D_VLD); end
        checks++; if (u_if.TX_P_DATA !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h required 00", u_if.TX_P_DATA); end
        checks++; if ({u_if.RSP_VLD, u_if.RSP_ERR, u_if.BUSY} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b required 000", {u_if.RSP_VLD, u_if.RSP_ERR, u_if.BUSY}); end
        checks++; if (u_if.RSP_DATA !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got %h required 0000", u_if.RSP_DATA); end
        RST = 1'b1;
        @(negedge CLK);
        $display("txn reset released");
    endtask

    task automatic test_write();
        g_rx_bytes.delete();
        do_request(2'd0, 4'd5, 8'h3C, 8'h00, 4'h0, 0, 0, 1'b0, 20);
        checks++; if (pk_seen() !== 40'h03_AA053C00) begin errors++; $display("FAIL write_frame got %h required 03AA053C00", pk_seen()); end
        checks++; if (g_tx_cycles != 3) begin errors++; $display("FAIL write_tx_cycles got %0d required 3", g_tx_cycles); end
        checks++; if (g_rsp_seen !== 1'b1 || g_latency != 0) begin errors++; $display("FAIL write_rsp_timing seen=%b lat=%0d required 1/0", g_rsp_seen, g_latency); end
        checks++; if ({g_rsp_err, g_rsp_data} !== 17'h0) begin errors++; $display("FAIL write_rsp got err=%b data=%h required 0/0000", g_rsp_err, g_rsp_data); end
        checks++; if (g_vld_after !== 1'b0 || g_rdy_after !== 1'b1) begin errors++; $display("FAIL write_after vld=%b rdy=%b required 0/1", g_vld_after, g_rdy_after); end
    endtask

    task automatic test_read_stall();
        g_rx_bytes.delete(); g_rx_bytes.push_back(8'h7E);
        do_request(2'd1, 4'd2, 8'h00, 8'h00, 4'h0, 2, 1, 1'b0, 50);
        checks++; if (pk_seen() !== 40'h02_BB020000) begin errors++; $display("FAIL read_frame got %h required 02BB020000", pk_seen()); end
        checks++; if (g_unstable != 0) begin errors++; $display("FAIL read_stall_stable got %0d changes required 0", g_unstable); end
        checks++; if (g_tx_cycles != 6) begin errors++; $display("FAIL read_tx_cycles got %0d required 6", g_tx_cycles); end
        checks++; if (g_rsp_seen !== 1'b1 || g_rsp_data !== 16'h007E || g_rsp_err !== 1'b0) begin errors++; $display("FAIL read_rsp seen=%b data=%h err=%b required 1/007E/0", g_rsp_seen, g_rsp_data, g_rsp_err); end
    endtask

    task automatic test_alu();
        g_rx_bytes.delete(); g_rx_bytes.push_back(8'h46); g_rx_bytes.push_back(8'h00);
        do_request(2'd2, 4'd0, 8'h12, 8'h34, 4'h0, 0, 2, 1'b0, 50);
        checks++; if (pk_seen() !== 40'h04_CC123400) begin errors++; $display("FAIL alu_frame got %h required 04CC123400", pk_seen()); end
        checks++; if (g_rsp_seen !== 1'b1 || g_rsp_data !== 16'h0046 || g_rsp_err !== 1'b0) begin errors++; $display("FAIL alu_rsp seen=%b data=%h err=%b required 1/0046/0", g_rsp_seen, g_rsp_data, g_rsp_err); end
    endtask

    task automatic test_alu_nop_stray();
        g_rx_bytes.delete(); g_rx_bytes.push_back(8'hA8); g_rx_bytes.push_back(8'h03);
        do_request(2'd3, 4'd0, 8'h00, 8'h00, 4'h2, 1, 0, 1'b1, 50);
        checks++; if (pk_seen() !== 40'h02_DD020000) begin errors++; $display("FAIL nop_frame got %h required 02DD020000", pk_seen()); end
        checks++; if (g_rsp_seen !== 1'b1 || g_rsp_data !== 16'h03A8 || g_rsp_err !== 1'b0) begin errors++; $display("FAIL nop_rsp seen=%b data=%h err=%b required 1/03A8/0", g_rsp_seen, g_rsp_data, g_rsp_err); end
    endtask

    task automatic test_timeout();
`ifdef CMD_MASTER_TIMEOUT_EN
        g_rx_bytes.delete();
        do_request(2'd1, 4'd9, 8'h00, 8'h00, 4'h0, 0, 0, 1'b0, 40);
        checks++; if (g_rsp_seen !== 1'b1 || g_latency != 16) begin errors++; $display("FAIL timeout_latency seen=%b lat=%0d required 1/16", g_rsp_seen, g_latency); end
        checks++; if (g_rsp_err !== 1'b1 || g_rsp_data !== 16'h0000) begin errors++; $display("FAIL timeout_rsp err=%b data=%h required 1/0000", g_rsp_err, g_rsp_data); end
        checks++; if (g_rdy_after !== 1'b1) begin errors++; $display("FAIL timeout_rdy got %b required 1", g_rdy_after); end
        g_rx_bytes.delete(); g_rx_bytes.push_back(8'h5B);
        do_request(2'd3, 4'd0, 8'h00, 8'h00, 4'h1, 0, 0, 1'b0, 60);
        checks++; if (g_rsp_seen !== 1'b1 || g_latency != 17) begin errors++; $display("FAIL partial_latency seen=%b lat=%0d required 1/17", g_rsp_seen, g_latency); end
        checks++; if (g_rsp_err !== 1'b1 || g_rsp_data !== 16'h005B) begin errors++; $display("FAIL partial_rsp err=%b data=%h required 1/005B", g_rsp_err, g_rsp_data); end
        g_rx_bytes.delete(); g_rx_bytes.push_back(8'h11);
        do_request(2'd1, 4'd3, 8'h00, 8'h00, 4'h0, 0, 1, 1'b0, 40);
        checks++; if (g_rsp_seen !== 1'b1 || g_rsp_err !== 1'b0 || g_rsp_data !== 16'h0011) begin errors++; $display("FAIL recover_rsp seen=%b err=%b data=%h required 1/0/0011", g_rsp_seen, g_rsp_err, g_rsp_data); end
`else
        int n;
        logic seen;
        g_rx_bytes.delete();
        do_request(2'd1, 4'd9, 8'h00, 8'h00, 4'h0, 0, 0, 1'b0, 1000);
        checks++; if (g_rsp_seen !== 1'b0) begin errors++; $display("FAIL no_timeout_rsp seen=%b required 0", g_rsp_seen); end
        checks++; if (u_if.BUSY !== 1'b1) begin errors++; $display("FAIL no_timeout_busy got %b required 1", u_if.BUSY); end
        u_if.RX_P_DATA = 8'h99; u_if.RX_D_VLD = 1'b1;
        @(posedge CLK); @(negedge CLK);
        u_if.RX_D_VLD = 1'b0;
        seen = 1'b0; n = 0;
        while (!seen && n < 10) begin
            if (u_if.RSP_VLD === 1'b1) begin
                seen = 1'b1; g_rsp_data = u_if.RSP_DATA; g_rsp_err = u_if.RSP_ERR;
            end else begin
                @(negedge CLK); n++;
            end
        end
        checks++; if (seen !== 1'b1 || g_rsp_data !== 16'h0099 || g_rsp_err !== 1'b0) begin errors++; $display("FAIL late_rsp seen=%b data=%h err=%b required 1/0099/0", seen, g_rsp_data, g_rsp_err); end
        $display("txn late read data=%h", g_rsp_data);
        @(negedge CLK);
`endif
    endtask

    task automatic test_reset_midframe();
        int vld_before;
        while (u_if.REQ_RDY !== 1'b1) @(negedge CLK);
        u_if.REQ_OP = 2'd2; u_if.REQ_ADDR = 4'd0; u_if.REQ_DATA = 8'h5A;
        u_if.REQ_OPB = 8'hC3; u_if.REQ_FUN = 4'h7; u_if.REQ_VLD = 1'b1; u_if.TX_RDY = 1'b1;
        @(posedge CLK); @(negedge CLK);
        u_if.REQ_VLD = 1'b0;
        @(posedge CLK); @(negedge CLK);
        checks++; if (u_if.TX_P_DATA !== 8'h5A || u_if.TX_D_VLD !== 1'b1) begin errors++; $display("FAIL midframe_byte2 got %h vld=%b required 5A/1", u_if.TX_P_DATA, u_if.TX_D_VLD); end
        vld_before = g_vld_cnt;
        #2 RST = 1'b0;
        #1;
        checks++; if ({u_if.REQ_RDY, u_if.TX_D_VLD, u_if.RSP_VLD, u_if.RSP_ERR, u_if.BUSY} !== 5'b10000 || u_if.TX_P_DATA !== 8'h00 || u_if.RSP_DATA !== 16'h0) begin
            errors++; $display("FAIL async_reset flags=%b tx=%h rsp=%h required 10000/00/0000",
                {u_if.REQ_RDY, u_if.TX_D_VLD, u_if.RSP_VLD, u_if.RSP_ERR, u_if.BUSY}, u_if.TX_P_DATA, u_if.RSP_DATA);
        end
        u_if.TX_RDY = 1'b0;
        u_if.RX_P_DATA = 8'hEE; u_if.RX_D_VLD = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        u_if.RX_D_VLD = 1'b0;
        repeat (20) @(negedge CLK);
        checks++; if (g_vld_cnt != vld_before) begin errors++; $display("FAIL aborted_no_rsp got %0d pulses required 0", g_vld_cnt - vld_before); end
        g_rx_bytes.delete();
        do_request(2'd0, 4'hF, 8'h81, 8'h00, 4'h0, 0, 0, 1'b0, 20);
        checks++; if (pk_seen() !== 40'h03_AA0F8100) begin errors++; $display("FAIL post_reset_frame got %h required 03AA0F8100", pk_seen()); end
        checks++; if (g_rsp_seen !== 1'b1 || g_rsp_err !== 1'b0 || g_rsp_data !== 16'h0) begin errors++; $display("FAIL post_reset_rsp seen=%b err=%b data=%h required 1/0/0000", g_rsp_seen, g_rsp_err, g_rsp_data); end
    endtask

    task automatic test_random_back_to_back();
        logic [1:0] op;
        logic [3:0] addr, fun;
        logic [7:0] data, opb;
        logic [15:0] exp_rsp;
        for (int it = 0; it < 24; it++) begin
            op = 2'($urandom_range(0, 3));
            addr = 4'($urandom); fun = 4'($urandom);
            data = 8'($urandom); opb = 8'($urandom);
            g_rx_bytes.delete();
            for (int k = 0; k < model_rsp_len(op); k++) g_rx_bytes.push_back(8'($urandom));
            exp_rsp = model_rsp(op);
            do_request(op, addr, data, opb, fun, $urandom_range(0, 2), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), 60);
            checks++; if (pk_seen() !== pk_exp()) begin errors++; $display("FAIL rnd_frame[%0d] got %h required %h", it, pk_seen(), pk_exp()); end
            checks++; if (g_rsp_seen !== 1'b1) begin errors++; $display("FAIL rnd_seen[%0d] got %b required 1", it, g_rsp_seen); end
            checks++; if (g_rsp_data !== exp_rsp || g_rsp_err !== 1'b0) begin errors++; $display("FAIL rnd_rsp[%0d] got %h/%b required %h/0", it, g_rsp_data, g_rsp_err, exp_rsp); end
            checks++; if (g_vld_after !== 1'b0 || g_rdy_after !== 1'b1) begin errors++; $display("FAIL rnd_after[%0d] vld=%b rdy=%b required 0/1", it, g_vld_after, g_rdy_after); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_stall();
        test_alu();
        test_alu_nop_stray();
        test_timeout();
        test_reset_midframe();
        test_random_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
